// File: rtl/alu_arb_pkg.sv
// rtl/alu_arb_pkg.sv - opcode constants and requester index type for alu_arbiter
package alu_arb_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SLL = 4'b0100;
    localparam logic [3:0] ALU_SRL = 4'b0101;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SRA = 4'b0111;
    localparam logic [3:0] ALU_EQ  = 4'b1000;
    localparam logic [3:0] ALU_GE  = 4'b1001;
    localparam logic [3:0] ALU_LT  = 4'b1100;

    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } req_id_t;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - shared combinational ALU used by alu_arbiter
module alu
    import alu_arb_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic [DATA_WIDTH-1:0]    srca,
    input  logic [DATA_WIDTH-1:0]    srcb,
    input  logic [OPCODE_LENGTH-1:0] op,
    output logic [DATA_WIDTH-1:0]    result
);

    logic [4:0] shamt;
    assign shamt = srcb[4:0];

    // Unlisted opcodes fall through to zero.
    always_comb begin
        result = '0;
        case (op)
            OPCODE_LENGTH'(ALU_AND): result = srca & srcb;
            OPCODE_LENGTH'(ALU_OR):  result = srca | srcb;
            OPCODE_LENGTH'(ALU_ADD): result = srca + srcb;
            OPCODE_LENGTH'(ALU_XOR): result = srca ^ srcb;
            OPCODE_LENGTH'(ALU_SLL): result = srca << shamt;
            OPCODE_LENGTH'(ALU_SRL): result = srca >> shamt;
            OPCODE_LENGTH'(ALU_SUB): result = srca - srcb;
            OPCODE_LENGTH'(ALU_SRA): result = DATA_WIDTH'($signed(srca) >>> shamt);
            OPCODE_LENGTH'(ALU_EQ):  result = DATA_WIDTH'(srca == srcb);
            OPCODE_LENGTH'(ALU_GE):  result = DATA_WIDTH'($signed(srca) >= $signed(srcb));
            OPCODE_LENGTH'(ALU_LT):  result = DATA_WIDTH'($signed(srca) < $signed(srcb));
            default:                 result = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester arbiter over one ALU with a result register; ALU_ARB_ROUND_ROBIN_EN selects round-robin
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     r0_valid,
    output logic                     r0_ready,
    input  logic [DATA_WIDTH-1:0]    r0_srca,
    input  logic [DATA_WIDTH-1:0]    r0_srcb,
    input  logic [OPCODE_LENGTH-1:0] r0_op,
    input  logic                     r1_valid,
    output logic                     r1_ready,
    input  logic [DATA_WIDTH-1:0]    r1_srca,
    input  logic [DATA_WIDTH-1:0]    r1_srcb,
    input  logic [OPCODE_LENGTH-1:0] r1_op,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic                     res_id,
    output logic [DATA_WIDTH-1:0]    res_data
);

`ifdef ALU_ARB_ROUND_ROBIN_EN
    localparam bit ROUND_ROBIN = 1'b1;
`else
    localparam bit ROUND_ROBIN = 1'b0;
`endif

    req_id_t                  last_grant;
    req_id_t                  grant_sel;
    req_id_t                  res_id_q;
    logic                     slot_free;
    logic                     accept;
    logic [DATA_WIDTH-1:0]    sel_srca;
    logic [DATA_WIDTH-1:0]    sel_srcb;
    logic [OPCODE_LENGTH-1:0] sel_op;
    logic [DATA_WIDTH-1:0]    alu_result;

    assign slot_free = !res_valid || res_ready;

    // Contention only consults last_grant in the round-robin build.
    always_comb begin
        grant_sel = REQ0;
        if (r0_valid && r1_valid)
            grant_sel = (ROUND_ROBIN && last_grant == REQ0) ? REQ1 : REQ0;
        else if (r1_valid)
            grant_sel = REQ1;
    end

    assign accept   = (r0_valid || r1_valid) && slot_free && !reset;
    assign r0_ready = accept && (grant_sel == REQ0);
    assign r1_ready = accept && (grant_sel == REQ1);

    assign sel_srca = (grant_sel == REQ1) ? r1_srca : r0_srca;
    assign sel_srcb = (grant_sel == REQ1) ? r1_srcb : r0_srcb;
    assign sel_op   = (grant_sel == REQ1) ? r1_op   : r0_op;

    alu #(
        .DATA_WIDTH    (DATA_WIDTH),
        .OPCODE_LENGTH (OPCODE_LENGTH)
    ) u_alu (
        .srca   (sel_srca),
        .srcb   (sel_srcb),
        .op     (sel_op),
        .result (alu_result)
    );

    // A new accept overrides consumption, giving back-to-back results.
    always_ff @(posedge clk) begin
        if (reset) begin
            res_valid  <= 1'b0;
            res_data   <= '0;
            res_id_q   <= REQ0;
            last_grant <= REQ1;
        end else if (accept) begin
            res_valid  <= 1'b1;
            res_data   <= alu_result;
            res_id_q   <= grant_sel;
            last_grant <= grant_sel;
        end else if (res_ready) begin
            res_valid  <= 1'b0;
        end
    end

    assign res_id = res_id_q;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, operand/result width.
REQ-002 Parameter OPCODE_LENGTH, default 4, ALU operation code width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 r0_valid / r1_valid  input  1  requester 0/1 has a pending operation.
REQ-006 r0_ready / r1_ready  output  1  requester 0/1 operation accepted this cycle.
REQ-007 r0_srca, r0_srcb, r1_srca, r1_srcb  input  DATA_WIDTH  operands per requester.
REQ-008 r0_op / r1_op  input  OPCODE_LENGTH  ALU operation code per requester.
REQ-009 res_valid  output  1  result register holds an unconsumed result.
REQ-010 res_ready  input  1  consumer accepts result this cycle.
REQ-011 res_id  output  1  requester index that produced res_data.
REQ-012 res_data  output  DATA_WIDTH  registered ALU result.

Function
REQ-013 Handshake: a transfer occurs when valid and ready are both high in the same cycle; requesters hold valid, operands and op stable until ready.
REQ-014 slot_free = !res_valid || res_ready; no requester ready while slot_free is low.
REQ-015 At most one of r0_ready/r1_ready high per cycle; ready only to the granted requester, and only when its valid is high.
REQ-016 Accepted operation computed combinationally by the shared ALU; result, id captured in the result register at the accepting edge; res_valid high the next cycle (latency 1).
REQ-017 Throughput 1 op/cycle: result consumed and new op accepted in the same cycle replaces the register without a bubble.
REQ-018 res_valid drops only when res_ready high and no new op accepted that cycle; res_data/res_id held stable while res_valid high and res_ready low.
REQ-019 Opcodes: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 SLL, 0101 SRL, 0110 SUB, 0111 SRA, 1000 EQ, 1001 GE, 1100 LT; any other code yields result 0.
REQ-020 Arithmetic wraps modulo 2^DATA_WIDTH; shifts use srcb[4:0]; SRA arithmetic; GE/LT signed; compare results zero-extended 0/1.
REQ-021 Only one valid: that requester is granted (subject to slot_free) regardless of arbitration pointer.
REQ-022 Arbitration pointer (last_grant) updates only on an accepted transfer; a stalled grant does not move it.

Reset
REQ-023 On reset: res_valid=0, res_data=0, res_id=0, last_grant=1 (requester 0 wins the first contention); r0_ready/r1_ready low during reset.
REQ-024 Reset mid-operation discards any held result; no transfer is counted in the reset cycle.

Configuration
REQ-025 Macro ALU_ARB_ROUND_ROBIN_EN defined: both valid -> grant the requester other than last_grant (strict alternation under continuous contention).
REQ-026 Macro undefined: fixed priority, requester 0 always wins contention; last_grant still tracked but unused.

Structure
REQ-027 Package alu_arb_pkg holds opcode localparams (ALU_AND ... ALU_LT) and the requester-index typedef.
REQ-028 One sub-module: alu, instantiated once, operand/op mux in front of it; arbitration and result register in alu_arbiter.

Verification
REQ-029 r0: ADD 5,7, res_ready=1 -> next cycle res_valid=1, res_id=0, res_data=12.
REQ-030 r1: SUB 3,5 -> res_data=0xFFFFFFFE, res_id=1; r1: op 1111 -> res_data=0.
REQ-031 RR_EN, both valid 4 cycles, res_ready=1 -> res_id sequence 0,1,0,1; without macro -> 0,0,0,0 and r1_ready never high.
REQ-032 Result held, res_ready=0 for 3 cycles, both valid -> both ready low, res_data unchanged; res_ready=1 -> next op accepted same cycle, no bubble.
REQ-033 Reset asserted while res_valid=1 -> next cycle res_valid=0, res_data=0; after release, contention grants requester 0.
REQ-034 SRA 0x80000000 by 4 -> 0xF8000000; LT -1,1 -> 1; GE 2,2 -> 1.
